// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package cpu_pkg;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } ctrl_state_e;

  localparam logic [5:0] REG_ZERO = 6'd0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard-controller bundle: pipeline register ids/strobes in, stage controls and perf counters out.
interface pipeline_ctrl_if import cpu_pkg::*; #(parameter int CNT_W = 32);

  logic [5:0]       dec_rs1, dec_rs2;
  logic             dec_uses_rs1, dec_uses_rs2;
  logic [5:0]       dec_exec_rs1, dec_exec_rs2, dec_exec_rd;
  logic             dec_exec_mem_r;
  logic [5:0]       exec_mem_rd;
  logic             exec_mem_writeback;
  logic [5:0]       mem_wb_rd;
  logic             mem_wb_writeback;
  logic             exec_mem_brnch_taken;
  logic             dmem_busy;
  fwd_sel_e         fwd_a_sel, fwd_b_sel;
  logic             stall_fetch, stall_dec, bubble_exec, stall_mem;
  logic             flush_dec, flush_exec, redirect;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
           dec_exec_rs1, dec_exec_rs2, dec_exec_rd, dec_exec_mem_r,
           exec_mem_rd, exec_mem_writeback, mem_wb_rd, mem_wb_writeback,
           exec_mem_brnch_taken, dmem_busy,
    input  fwd_a_sel, fwd_b_sel, stall_fetch, stall_dec, bubble_exec, stall_mem,
           flush_dec, flush_exec, redirect, stall_cnt, flush_cnt
  );

  modport slave (
    input  dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
           dec_exec_rs1, dec_exec_rs2, dec_exec_rd, dec_exec_mem_r,
           exec_mem_rd, exec_mem_writeback, mem_wb_rd, mem_wb_writeback,
           exec_mem_brnch_taken, dmem_busy,
    output fwd_a_sel, fwd_b_sel, stall_fetch, stall_dec, bubble_exec, stall_mem,
           flush_dec, flush_exec, redirect, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_fwd_select.sv
// Per-operand forwarding source select; EX/MEM result is newer so it beats MEM/WB.
module fwd_select import cpu_pkg::*; (
  input  logic [5:0] rs,
  input  logic [5:0] exmem_rd,
  input  logic       exmem_wb,
  input  logic [5:0] memwb_rd,
  input  logic       memwb_wb,
  output fwd_sel_e   sel
);

  always_comb begin
    sel = FWD_REG;
    if (rs != REG_ZERO && exmem_wb && rs == exmem_rd)
      sel = FWD_EXMEM;
    else if (rs != REG_ZERO && memwb_wb && rs == memwb_rd)
      sel = FWD_MEMWB;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard controller: forwarding selects, load-use bubbles, dmem wait stalls,
// branch redirect/flush sequencing and saturating stall/flush perf counters.
module pipeline_ctrl import cpu_pkg::*; #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  pipeline_ctrl_if.slave bus
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  ctrl_state_e      state, state_nx;
  logic [3:0]       flush_left, flush_left_nx;
  logic             pending, pending_nx;
  logic             load_use, do_redirect;
  logic             stall_fetch, stall_dec, bubble_exec, stall_mem;
  logic             flush_dec, flush_exec, redirect;
  fwd_sel_e         fwd_a_raw, fwd_b_raw;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  fwd_select u_fwd_a (
    .rs       (bus.dec_exec_rs1),
    .exmem_rd (bus.exec_mem_rd),
    .exmem_wb (bus.exec_mem_writeback),
    .memwb_rd (bus.mem_wb_rd),
    .memwb_wb (bus.mem_wb_writeback),
    .sel      (fwd_a_raw)
  );

  fwd_select u_fwd_b (
    .rs       (bus.dec_exec_rs2),
    .exmem_rd (bus.exec_mem_rd),
    .exmem_wb (bus.exec_mem_writeback),
    .memwb_rd (bus.mem_wb_rd),
    .memwb_wb (bus.mem_wb_writeback),
    .sel      (fwd_b_raw)
  );

  assign load_use = bus.dec_exec_mem_r && (bus.dec_exec_rd != REG_ZERO) &&
                    ((bus.dec_uses_rs1 && bus.dec_rs1 == bus.dec_exec_rd) ||
                     (bus.dec_uses_rs2 && bus.dec_rs2 == bus.dec_exec_rd));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      flush_left <= '0;
      pending    <= 1'b0;
    end else begin
      state      <= state_nx;
      flush_left <= flush_left_nx;
      pending    <= pending_nx;
    end
  end

  // A branch resolved while dmem is busy is parked in 'pending' and replayed on the busy-drop cycle.
  always_comb begin
    state_nx      = state;
    flush_left_nx = flush_left;
    pending_nx    = pending;
    do_redirect   = 1'b0;
    stall_fetch   = 1'b0;
    stall_dec     = 1'b0;
    bubble_exec   = 1'b0;
    stall_mem     = 1'b0;
    flush_dec     = 1'b0;
    flush_exec    = 1'b0;
    redirect      = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.dmem_busy) begin
          stall_fetch = 1'b1;
          stall_dec   = 1'b1;
          stall_mem   = 1'b1;
          pending_nx  = bus.exec_mem_brnch_taken;
          state_nx    = MEM_WAIT;
        end else if (bus.exec_mem_brnch_taken) begin
          do_redirect = 1'b1;
        end else if (load_use) begin
          stall_fetch = 1'b1;
          stall_dec   = 1'b1;
          bubble_exec = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_busy) begin
          stall_fetch = 1'b1;
          stall_dec   = 1'b1;
          stall_mem   = 1'b1;
          if (bus.exec_mem_brnch_taken) pending_nx = 1'b1;
        end else if (pending || bus.exec_mem_brnch_taken) begin
          do_redirect = 1'b1;
        end else begin
          state_nx = RUN;
        end
      end
      FLUSH: begin
        flush_dec     = 1'b1;
        stall_mem     = bus.dmem_busy;
        flush_left_nx = flush_left - 4'd1;
        if (flush_left <= 4'd1) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
    if (do_redirect) begin
      redirect      = 1'b1;
      flush_dec     = 1'b1;
      flush_exec    = 1'b1;
      pending_nx    = 1'b0;
      flush_left_nx = FLUSH_LOAD;
      if (FLUSH_LOAD != 4'd0) state_nx = FLUSH;
      else                    state_nx = RUN;
    end
    if (!rst_n) begin
      stall_fetch = 1'b0;
      stall_dec   = 1'b0;
      bubble_exec = 1'b0;
      stall_mem   = 1'b0;
      flush_dec   = 1'b0;
      flush_exec  = 1'b0;
      redirect    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_fetch && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect && flush_cnt != '1)    flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    bus.fwd_a_sel = FWD_REG;
    bus.fwd_b_sel = FWD_REG;
    if (rst_n) begin
      bus.fwd_a_sel = fwd_a_raw;
      bus.fwd_b_sel = fwd_b_raw;
    end
  end

  assign bus.stall_fetch = stall_fetch;
  assign bus.stall_dec   = stall_dec;
  assign bus.bubble_exec = bubble_exec;
  assign bus.stall_mem   = stall_mem;
  assign bus.flush_dec   = flush_dec;
  assign bus.flush_exec  = flush_exec;
  assign bus.redirect    = redirect;
  assign bus.stall_cnt   = stall_cnt;
  assign bus.flush_cnt   = flush_cnt;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard controller for the 5-stage core (fetch, decode, execute, mem, writeback).
- Produces operand-forwarding selects for the execute-stage ALU muxes.
- Produces stall, bubble and flush controls for the pipeline registers, and the PC redirect strobe.
- Sequences load-use stalls, data-memory wait states and branch-taken flushes; keeps saturating performance counters.

Parameters:
- FLUSH_CYCLES, 2, cycles flush_dec stays asserted after a redirect (covers fetch latency); legal range 1..15.
- CNT_W, 32, width of the perf counters.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- dec_rs1  in  6  rs1 of the instruction in decode
- dec_rs2  in  6  rs2 of the instruction in decode
- dec_uses_rs1  in  1  decode instruction reads rs1
- dec_uses_rs2  in  1  decode instruction reads rs2
- dec_exec_rs1  in  6  rs1 of the instruction in execute
- dec_exec_rs2  in  6  rs2 of the instruction in execute
- dec_exec_rd  in  6  rd of the instruction in execute
- dec_exec_mem_r  in  1  execute instruction is a load
- exec_mem_rd  in  6  rd in the mem stage
- exec_mem_writeback  in  1  mem-stage instruction writes rd
- mem_wb_rd  in  6  rd in writeback
- mem_wb_writeback  in  1  writeback instruction writes rd
- exec_mem_brnch_taken  in  1  branch resolved taken (mem stage)
- dmem_busy  in  1  data memory not ready this cycle
- fwd_a_sel  out  2  ALU operand A source
- fwd_b_sel  out  2  ALU operand B source
- stall_fetch  out  1  hold PC and fetch register
- stall_dec  out  1  hold the decode/execute register
- bubble_exec  out  1  load NOP into the decode/execute register
- stall_mem  out  1  hold execute/mem and mem/writeback registers
- flush_dec  out  1  invalidate fetch/decode contents
- flush_exec  out  1  invalidate decode/execute contents
- redirect  out  1  one-cycle strobe: PC takes the branch target address
- stall_cnt  out  CNT_W  cycles with stall_fetch high (saturating)
- flush_cnt  out  CNT_W  redirects taken (saturating)

Behaviour:
- Reset (rst_n low, asynchronous):
  - State is RUN; flush counter, pending flag and perf counters are 0.
  - All 1-bit outputs are 0; fwd selects are FWD_REG.
- Forwarding is combinational and applies to operand A (dec_exec_rs1) and operand B (dec_exec_rs2):
  - FWD_EXMEM (1) if rs==exec_mem_rd, exec_mem_writeback, and rs!=0.
  - Else FWD_MEMWB (2) if rs==mem_wb_rd, mem_wb_writeback, and rs!=0.
  - Else FWD_REG (0). EX/MEM has priority over MEM/WB.
- Load-use hazard (combinational, RUN only):
  - Condition: dec_exec_mem_r, dec_exec_rd!=0, and (dec_uses_rs1 with dec_rs1==dec_exec_rd, or dec_uses_rs2 with dec_rs2==dec_exec_rd).
  - Response: stall_fetch=1, stall_dec=1, bubble_exec=1 for exactly that cycle; exactly one bubble per load.
- State machine (states RUN, MEM_WAIT, FLUSH):
  - RUN, dmem_busy=1: go to MEM_WAIT. Same cycle: stall_fetch, stall_dec, stall_mem=1; no bubble.
  - RUN, exec_mem_brnch_taken=1 and dmem_busy=0: redirect=1, flush_dec=1, flush_exec=1; go to FLUSH; counter loads FLUSH_CYCLES-1.
  - MEM_WAIT: all stall outputs held at 1 while dmem_busy=1.
    - A branch-taken seen entering MEM_WAIT or during it sets the pending flag.
    - On dmem_busy=0: if pending, perform the redirect sequence that cycle and go to FLUSH; else go to RUN.
  - FLUSH: flush_dec=1 each cycle; counter decrements; at 0, go to RUN.
    - dmem_busy in FLUSH stalls mem (stall_mem=1) but does not stop the counter.
    - A new taken branch in FLUSH cannot occur (flushed); ignore it.
- Priority within a cycle: dmem_busy > branch taken > load-use. A load-use hazard coincident with a taken branch is dropped (the flush wins).
- Perf counters:
  - stall_cnt increments on each cycle stall_fetch=1; flush_cnt increments on each redirect.
  - Both hold at all-ones.
- Reset asserted mid-MEM_WAIT or mid-FLUSH: immediate return to RUN; pending flag cleared.

Decomposition:
- cpu_pkg holds:
  - fwd_sel_e (FWD_REG=0, FWD_EXMEM=1, FWD_MEMWB=2);
  - ctrl_state_e (RUN, MEM_WAIT, FLUSH);
  - REG_ZERO constant (6'd0).
- Sub-module fwd_select: the per-operand comparator/priority logic, instantiated twice (operand A, operand B).

Test Plan:
- Forwarding priority: rs1=5; exec_mem_rd=5 with wb=1; mem_wb_rd=5 with wb=1 -> fwd_a_sel=1. Drop exec_mem_writeback -> fwd_a_sel=2. rs1=0 with all rd=0 -> fwd_a_sel=0.
- Load-use: load rd=7 in execute, decode uses rs2=7 -> stall_fetch, stall_dec and bubble_exec high exactly 1 cycle; stall_cnt=1.
- Branch flush with FLUSH_CYCLES=2: brnch_taken pulse -> redirect 1 cycle, flush_exec 1 cycle, flush_dec 2 cycles; back in RUN on cycle 3; flush_cnt=1.
- Memory wait: dmem_busy high 4 cycles -> stall_fetch, stall_dec and stall_mem high those 4 cycles; stall_cnt=4; no bubble.
- Branch during wait: brnch_taken while dmem_busy=1 -> no redirect until the busy-drop cycle, then exactly one redirect.
- Async reset mid-FLUSH: rst_n low in the 2nd flush cycle -> all outputs 0 without a clock edge; after release, state is RUN.
